// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-store arbiter: data width, FSM state encoding
// and port indices.
package mem_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way winner select; the last-grant pointer is owned by the caller.
module rr_arb2
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       win
);

  // Winner select: a lone requester always wins, a tie goes by policy.
  always_comb begin
    valid = |req;
    win   = PORT_CPU;
    if (req == 2'b11) begin
      if (FIXED != 0) begin
        win = PORT_CPU;
      end else begin
        win = ~last;
      end
    end else if (req[1]) begin
      win = PORT_LDR;
    end else begin
      win = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port main store; grants one
// port at a time, holds strobes through wait, returns read data with a one-cycle ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ABITS = 9,
  parameter int FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ABITS-1:0]  p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ABITS-1:0]  p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ABITS-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_wait
);

  arb_state_e        state_r, state_s;
  logic              last_r, last_s;
  logic              gnt_r, gnt_s;
  logic              we_r, we_s;
  logic [ABITS-1:0]  addr_r, addr_s;
  logic [DATA_W-1:0] d_r, d_s;
  logic              rd_r, rd_s;
  logic              wr_r, wr_s;
  logic              ack0_r, ack0_s;
  logic              ack1_r, ack1_s;
  logic [DATA_W-1:0] rdata0_r, rdata0_s;
  logic [DATA_W-1:0] rdata1_r, rdata1_s;
  logic              valid_s;
  logic              win_s;

  rr_arb2 #(.FIXED(FIXED)) u_arb (
    .req   ({p1_req, p0_req}),
    .last  (last_r),
    .valid (valid_s),
    .win   (win_s)
  );

  // Next-state and next-output logic; acks default low so they pulse for one cycle.
  always_comb begin
    state_s  = state_r;
    last_s   = last_r;
    gnt_s    = gnt_r;
    we_s     = we_r;
    addr_s   = addr_r;
    d_s      = d_r;
    rd_s     = rd_r;
    wr_s     = wr_r;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    rdata0_s = rdata0_r;
    rdata1_s = rdata1_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          gnt_s  = win_s;
          last_s = win_s;
          if (win_s == PORT_LDR) begin
            we_s   = p1_we;
            addr_s = p1_addr;
            d_s    = p1_wdata;
          end else begin
            we_s   = p0_we;
            addr_s = p0_addr;
            d_s    = p0_wdata;
          end
          rd_s    = ~we_s;
          wr_s    = we_s;
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!mem_wait) begin
          rd_s = 1'b0;
          wr_s = 1'b0;
          if (we_r) begin
            if (gnt_r == PORT_LDR) begin
              ack1_s = 1'b1;
            end else begin
              ack0_s = 1'b1;
            end
            state_s = ST_DONE;
          end else begin
            state_s = ST_RDATA;
          end
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_RDATA: begin
        if (gnt_r == PORT_LDR) begin
          rdata1_s = mem_q;
          ack1_s   = 1'b1;
        end else begin
          rdata0_s = mem_q;
          ack0_s   = 1'b1;
        end
        state_s = ST_DONE;
      end
      ST_DONE: begin
        // Ack cycle: no grant here, giving the requester time to drop req.
        state_s = ST_IDLE;
      end
      default: begin
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      last_r   <= PORT_LDR;
      gnt_r    <= PORT_CPU;
      we_r     <= 1'b0;
      addr_r   <= {ABITS{1'b0}};
      d_r      <= {DATA_W{1'b0}};
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_s;
      last_r   <= last_s;
      gnt_r    <= gnt_s;
      we_r     <= we_s;
      addr_r   <= addr_s;
      d_r      <= d_s;
      rd_r     <= rd_s;
      wr_r     <= wr_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      rdata0_r <= rdata0_s;
      rdata1_r <= rdata1_s;
    end
  end

  assign mem_addr = addr_r;
  assign mem_d    = d_r;
  assign mem_rd   = rd_r;
  assign mem_wr   = wr_r;
  assign p0_ack   = ack0_r;
  assign p1_ack   = ack1_r;
  assign p0_rdata = rdata0_r;
  assign p1_rdata = rdata1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin and a fixed-priority instance,
// each with a behavioural store model, scoreboard and strobe monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AB = 9;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    logic          we;
    logic [AB-1:0] addr;
    logic [15:0]   data;
    int            lat;
  } txn_t;

  typedef struct {
    int            g;
    logic          port;
    logic          we;
    logic [AB-1:0] addr;
    logic [15:0]   data;
    int            wt;
    int            lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst       [2];
  logic          p_req     [2][2];
  logic          p_we      [2][2];
  logic [AB-1:0] p_addr    [2][2];
  logic [15:0]   p_wdata   [2][2];
  logic          p_ack     [2][2];
  logic [15:0]   p_rdata   [2][2];
  logic [AB-1:0] mem_addr  [2];
  logic [15:0]   mem_d     [2];
  logic [15:0]   mem_q     [2];
  logic          mem_rd    [2];
  logic          mem_wr    [2];
  logic          mem_wait  [2];
  int            wait_n    [2];
  int            wcnt      [2];
  logic [15:0]   store     [2][512];

  int            n_chk = 0;
  int            n_fail = 0;
  sb_t           sbq       [2][$];
  txn_t          pend      [2][$];
  int            cur_lat   [2];
  logic [15:0]   rd_model  [2][2];
  int            hi_cnt    [2];
  int            lo_cnt    [2];
  logic [AB+17:0] prev_bus [2];

  always #5 clk = ~clk;

  function automatic logic [15:0] preload(input int a);
    logic [15:0] v;
    v = 16'(a) ^ 16'hA500;
    if (a == 'h033) v = 16'h0042;
    return v;
  endfunction

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(.ABITS(AB), .FIXED(g)) u_dut (
        .clk      (clk),
        .reset    (rst[g]),
        .p0_req   (p_req[g][0]),
        .p0_we    (p_we[g][0]),
        .p0_addr  (p_addr[g][0]),
        .p0_wdata (p_wdata[g][0]),
        .p0_ack   (p_ack[g][0]),
        .p0_rdata (p_rdata[g][0]),
        .p1_req   (p_req[g][1]),
        .p1_we    (p_we[g][1]),
        .p1_addr  (p_addr[g][1]),
        .p1_wdata (p_wdata[g][1]),
        .p1_ack   (p_ack[g][1]),
        .p1_rdata (p_rdata[g][1]),
        .mem_addr (mem_addr[g]),
        .mem_d    (mem_d[g]),
        .mem_rd   (mem_rd[g]),
        .mem_wr   (mem_wr[g]),
        .mem_q    (mem_q[g]),
        .mem_wait (mem_wait[g])
      );

      // Store wait: asserted for the first wait_n strobe cycles of each access.
      assign mem_wait[g] = (mem_rd[g] | mem_wr[g]) && (wcnt[g] < wait_n[g]);

      // Store model: commits on strobe with wait low, q registered.
      always @(posedge clk) begin
        if (rst[g]) begin
          wcnt[g]  <= 0;
          mem_q[g] <= 16'h0000;
          for (int i = 0; i < 512; i++) store[g][i] <= preload(i);
        end else if (mem_rd[g] | mem_wr[g]) begin
          if (mem_wait[g]) begin
            wcnt[g] <= wcnt[g] + 1;
          end else begin
            wcnt[g] <= 0;
            if (mem_wr[g]) store[g][mem_addr[g]] <= mem_d[g];
            else mem_q[g] <= store[g][mem_addr[g]];
          end
        end else begin
          wcnt[g] <= 0;
        end
      end
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe gap/length/stability and scoreboard check of every ack.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        hi_cnt[g] = 0;
        lo_cnt[g] = 2;
      end else begin
        if (mem_rd[g] | mem_wr[g]) begin
          if (hi_cnt[g] == 0) check("strobe_gap", 32'(lo_cnt[g] >= 2), 32'd1);
          else check("strobe_stable", 32'(prev_bus[g] == {mem_addr[g], mem_d[g], mem_rd[g], mem_wr[g]}), 32'd1);
          prev_bus[g] = {mem_addr[g], mem_d[g], mem_rd[g], mem_wr[g]};
          hi_cnt[g]++;
          lo_cnt[g] = 0;
        end else begin
          if (hi_cnt[g] != 0) check("strobe_len", 32'(hi_cnt[g]), 32'(wait_n[g] + 1));
          hi_cnt[g] = 0;
          lo_cnt[g]++;
        end
        for (int p = 0; p < 2; p++) begin
          if (p_ack[g][p]) begin
            if (sbq[g].size() == 0) begin
              check("unexpected_ack", 32'(p), 32'hFFFF_FFFF);
            end else begin
              sb_t e;
              e = sbq[g].pop_front();
              check("ack_port", 32'(p), 32'(e.port));
              if (!e.we) rd_model[g][p] = e.data;
            end
          end
        end
        if (p_ack[g][0] | p_ack[g][1]) begin
          check("p0_rdata", 32'(p_rdata[g][0]), 32'(rd_model[g][0]));
          check("p1_rdata", 32'(p_rdata[g][1]), 32'(rd_model[g][1]));
        end
      end
    end
  end

  task automatic raise(input int g, input int p);
    txn_t t;
    t = pend[p].pop_front();
    p_req[g][p]   = 1'b1;
    p_we[g][p]    = t.we;
    p_addr[g][p]  = t.addr;
    p_wdata[g][p] = t.data;
    cur_lat[p]    = t.lat;
  endtask

  // Serve the pending per-port queues on instance g; a port re-requests in its ack cycle.
  task automatic play(input int g);
    int cnt[2];
    int budget;
    cnt = '{0, 0};
    budget = 0;
    for (int p = 0; p < 2; p++) if (pend[p].size() > 0) raise(g, p);
    while ((p_req[g][0] || p_req[g][1]) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
      for (int p = 0; p < 2; p++) begin
        if (p_req[g][p]) begin
          cnt[p]++;
          if (p_ack[g][p]) begin
            if (cur_lat[p] != 0) check("ack_latency", 32'(cnt[p]), 32'(cur_lat[p]));
            p_req[g][p] = 1'b0;
            cnt[p] = 0;
            if (pend[p].size() > 0) raise(g, p);
          end
        end
      end
    end
    if (budget >= 200) begin
      check("play_timeout", 32'(budget), 32'd0);
      p_req[g][0] = 1'b0;
      p_req[g][1] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (sbq[g].size() != 0) check("sb_leftover", 32'(sbq[g].size()), 32'd0);
  endtask

  task automatic queue_txn(input int g, input logic p, input logic we, input logic [AB-1:0] a,
                           input logic [15:0] d, input int lat);
    pend[p].push_back('{we: we, addr: a, data: d, lat: lat});
    sbq[g].push_back('{port: p, we: we, data: d});
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{0, 1'b0, 1'b1, 9'h005, 16'h1234, 0, 2},
      '{0, 1'b0, 1'b0, 9'h005, 16'h1234, 0, 3},
      '{0, 1'b0, 1'b0, 9'h010, 16'hA510, 3, 6},
      '{0, 1'b0, 1'b1, 9'h011, 16'h5555, 3, 5},
      '{0, 1'b0, 1'b0, 9'h011, 16'h5555, 1, 4},
      '{0, 1'b1, 1'b0, 9'h020, 16'hA520, 0, 3},
      '{0, 1'b1, 1'b1, 9'h040, 16'hBEEF, 0, 2},
      '{0, 1'b1, 1'b0, 9'h033, 16'h0042, 0, 3},
      '{0, 1'b1, 1'b0, 9'h040, 16'hBEEF, 0, 3},
      '{1, 1'b1, 1'b0, 9'h020, 16'hA520, 0, 3},
      '{1, 1'b0, 1'b1, 9'h1FF, 16'hFFFF, 0, 2},
      '{1, 1'b0, 1'b0, 9'h1FF, 16'hFFFF, 0, 3}
    };
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1;
      wait_n[g] = 0;
      for (int p = 0; p < 2; p++) begin
        p_req[g][p] = 1'b0;
        p_we[g][p] = 1'b0;
        p_addr[g][p] = 9'h000;
        p_wdata[g][p] = 16'h0000;
        rd_model[g][p] = 16'h0000;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_strobes", 32'({mem_rd[g], mem_wr[g]}), 32'd0);
      check("rst_acks", 32'({p_ack[g][0], p_ack[g][1]}), 32'd0);
      check("rst_rdata", 32'({p_rdata[g][0], p_rdata[g][1]}), 32'd0);
      check("rst_bus", 32'({mem_addr[g], mem_d[g]}), 32'd0);
      rst[g] = 1'b0;
    end

    // Single uncontended transactions with latency, wait and data checks.
    foreach (vecs[i]) begin
      wait_n[vecs[i].g] = vecs[i].wt;
      queue_txn(vecs[i].g, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].lat);
      play(vecs[i].g);
      wait_n[vecs[i].g] = 0;
    end

    // Round-robin contention: three rounds must alternate 0,1,0,1,0,1.
    for (int r = 0; r < 3; r++) begin
      queue_txn(0, 1'b0, 1'b0, 9'h010, 16'hA510, (r == 0) ? 3 : 0);
      queue_txn(0, 1'b1, 1'b0, 9'h020, 16'hA520, 0);
    end
    play(0);

    // Fixed priority: p0 re-requests in its ack cycle and keeps winning over p1.
    queue_txn(1, 1'b0, 1'b0, 9'h010, 16'hA510, 3);
    queue_txn(1, 1'b0, 1'b0, 9'h011, 16'hA511, 0);
    queue_txn(1, 1'b1, 1'b0, 9'h020, 16'hA520, 0);
    play(1);

    // Reset while the store holds wait in ACCESS.
    wait_n[0] = 100;
    @(negedge clk);
    p_req[0][0] = 1'b1;
    p_we[0][0] = 1'b1;
    p_addr[0][0] = 9'h007;
    p_wdata[0][0] = 16'h7777;
    repeat (3) @(posedge clk);
    #1;
    check("t5_wr_held", 32'(mem_wr[0]), 32'd1);
    rst[0] = 1'b1;
    p_req[0][0] = 1'b0;
    rd_model[0][0] = 16'h0000;
    rd_model[0][1] = 16'h0000;
    @(posedge clk);
    #1;
    check("t5_strobes", 32'({mem_rd[0], mem_wr[0]}), 32'd0);
    check("t5_acks", 32'({p_ack[0][0], p_ack[0][1]}), 32'd0);
    check("t5_rdata", 32'({p_rdata[0][0], p_rdata[0][1]}), 32'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    wait_n[0] = 0;
    queue_txn(0, 1'b1, 1'b0, 9'h007, 16'hA507, 3);
    play(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
